// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive path.
// Holds the receiver FSM encoding and the edge-counter width helper.
package spi_pkg;

    localparam int SPI_DATA_W      = 12;
    localparam int SPI_LEAD        = 1;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } spi_rx_state_t;

    // Counter must reach LEAD+DATA_W+1 (saturation value) without wrapping.
    function automatic int spi_cnt_w(input int lead, input int data_w);
        return $clog2(lead + data_w + 2);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-bit, SYNC_STAGES-deep flop-chain synchronizer with per-bit reset value.
// Latency SYNC_STAGES clk cycles; no backpressure.
module spi_sync #(
    parameter int           W           = 3,
    parameter int           SYNC_STAGES = 2,
    parameter logic [W-1:0] RST_VAL     = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stg_q [SYNC_STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stg_q[i] <= RST_VAL;
            end
        end else begin
            stg_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign q_o = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampling SPI receiver: rebuilds LSB-first DATA_W-bit frames from sclk/cs/mosi pins.
// Valid/error pulse SYNC_STAGES+1 clk after cs rises on the pin; no backpressure (pulses are not held).
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int LEAD        = SPI_LEAD,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int CNT_W = spi_cnt_w(LEAD, DATA_W);

    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(LEAD);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LEAD + DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(LEAD + DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LEAD + DATA_W + 1);

    // All three pins share one chain so mosi stays aligned with the sclk edge detect.
    logic [2:0] sync_vec;
    logic       cs_s;
    logic       sclk_s;
    logic       mosi_s;

    spi_sync #(
        .W           (3),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (3'b100)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({cs_i, sclk_i, mosi_i}),
        .q_o    (sync_vec)
    );

    assign {cs_s, sclk_s, mosi_s} = sync_vec;

    logic cs_prev_q;
    logic sclk_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    logic cs_fall;
    logic cs_rise;
    logic sclk_fall;

    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    spi_rx_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                // A cs_rise coinciding with an sclk fall closes the frame; that edge is dropped.
                if (cs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_DONE) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if ((cnt_q >= CNT_FIRST) && (cnt_q <= CNT_LAST)) begin
                        shift_d = {mosi_s, shift_q[DATA_W-1:1]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign frame_err_o  = err_q;
    assign busy_o       = (state_q == RECV);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: table of frames, hand-written corner sequences, then random frames
// checked against a frame-level model (good iff exactly LEAD+DATA_W sclk falls inside cs low).
module tb_spi_slave_rx;

    localparam int DW   = 12;
    localparam int LD   = 1;
    localparam int GOOD = LD + DW;
    localparam int HALF = 110;

    logic          clk;
    logic          rst_n;
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          frame_err;
    logic          busy;

    spi_slave_rx dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sclk_i       (sclk),
        .cs_i         (cs),
        .mosi_i       (mosi),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .frame_err_o  (frame_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int            vld_cnt  = 0;
    int            err_cnt  = 0;
    int            both_cnt = 0;
    int            busy_cyc = 0;
    logic [DW-1:0] words[$];

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            vld_cnt++;
            words.push_back(dout);
        end
        if (frame_err === 1'b1) err_cnt++;
        if (dout_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (busy === 1'b1) busy_cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // nf falling edges inside cs low; fall 0 is the lead edge, fall i>=1 carries bits[i-1].
    task automatic frame(input logic [31:0] bits, input int nf, input int gap);
        cs = 1'b0;
        #(HALF);
        for (int i = 0; i < nf; i++) begin
            sclk = 1'b1;
            if (i == 0) mosi = 1'($urandom_range(1, 0));
            else        mosi = bits[i-1];
            #(HALF);
            sclk = 1'b0;
            #(HALF);
        end
        cs = 1'b1;
        repeat (gap) @(posedge clk);
    endtask

    task automatic run_frame(input string nm, input logic [31:0] bits, input int nf,
                             input int exp_v, input int exp_e, input logic [DW-1:0] exp_d);
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        frame(bits, nf, 12);
        check({nm, " valid pulses"}, 32'(vld_cnt - v0), 32'(exp_v));
        check({nm, " error pulses"}, 32'(err_cnt - e0), 32'(exp_e));
        check({nm, " dout"}, 32'(dout), 32'(exp_d));
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            nf;
        int            exp_v;
        int            exp_e;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int            v0, e0, b0;
        logic [31:0]   rbits;
        int            rnf;
        logic [DW-1:0] model_dout;

        tbl[0] = '{12'hA5C, 13, 1, 0, 12'hA5C};
        tbl[1] = '{12'hFFF, 13, 1, 0, 12'hFFF};
        tbl[2] = '{12'h001, 13, 1, 0, 12'h001};
        tbl[3] = '{12'h7F0,  7, 0, 1, 12'h001};
        tbl[4] = '{12'h123, 15, 0, 1, 12'h001};
        tbl[5] = '{12'h456, 14, 0, 1, 12'h001};
        tbl[6] = '{12'h789, 12, 0, 1, 12'h001};
        tbl[7] = '{12'hABC,  0, 0, 1, 12'h001};
        tbl[8] = '{12'h800, 13, 1, 0, 12'h800};
        tbl[9] = '{12'h555, 13, 1, 0, 12'h555};

        rst_n = 1'b0;
        cs    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dout", 32'(dout), 32'h0);
        check("reset dout_valid", 32'(dout_valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            b0 = busy_cyc;
            run_frame($sformatf("tbl[%0d]", i), 32'(tbl[i].data), tbl[i].nf,
                      tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_d);
            check($sformatf("tbl[%0d] busy seen", i), 32'(busy_cyc > b0), 32'h1);
            check($sformatf("tbl[%0d] busy after", i), 32'(busy), 32'h0);
        end

        // Back-to-back frames with only two clk cycles of cs high between them.
        v0 = vld_cnt;
        e0 = err_cnt;
        frame(32'hFFF, GOOD, 2);
        frame(32'h001, GOOD, 12);
        check("b2b valid pulses", 32'(vld_cnt - v0), 32'd2);
        check("b2b error pulses", 32'(err_cnt - e0), 32'd0);
        if (words.size() >= 2) begin
            check("b2b first word", 32'(words[words.size()-2]), 32'hFFF);
            check("b2b second word", 32'(words[words.size()-1]), 32'h001);
        end else begin
            check("b2b word count", 32'(words.size()), 32'd2);
        end

        // sclk toggling with cs high must be ignored.
        v0 = vld_cnt;
        e0 = err_cnt;
        b0 = busy_cyc;
        for (int i = 0; i < 40; i++) begin
            sclk = 1'b1;
            mosi = 1'($urandom_range(1, 0));
            #(HALF);
            sclk = 1'b0;
            #(HALF);
        end
        repeat (8) @(posedge clk);
        check("cs-high valid pulses", 32'(vld_cnt - v0), 32'd0);
        check("cs-high error pulses", 32'(err_cnt - e0), 32'd0);
        check("cs-high busy cycles", 32'(busy_cyc - b0), 32'd0);
        check("cs-high dout", 32'(dout), 32'h001);

        // Reset after 6 payload bits of 12'h3C3, then a clean 12'h3C3 frame.
        v0 = vld_cnt;
        e0 = err_cnt;
        rbits = 32'h3C3;
        cs = 1'b0;
        #(HALF);
        for (int i = 0; i < 7; i++) begin
            sclk = 1'b1;
            if (i == 0) mosi = 1'b0;
            else        mosi = rbits[i-1];
            #(HALF);
            sclk = 1'b0;
            #(HALF);
        end
        @(posedge clk);
        check("abort busy mid-frame", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("abort dout in reset", 32'(dout), 32'h0);
        check("abort busy in reset", 32'(busy), 32'h0);
        cs = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check("abort valid pulses", 32'(vld_cnt - v0), 32'd0);
        check("abort error pulses", 32'(err_cnt - e0), 32'd0);
        check("abort dout after reset", 32'(dout), 32'h0);
        run_frame("after abort", 32'h3C3, GOOD, 1, 0, 12'h3C3);

        // Random frames against the frame-level model.
        model_dout = 12'h3C3;
        for (int i = 0; i < 30; i++) begin
            rbits = $urandom;
            if ($urandom_range(3, 0) == 0) rnf = $urandom_range(16, 0);
            else                           rnf = GOOD;
            if (rnf == GOOD) begin
                model_dout = rbits[DW-1:0];
                run_frame($sformatf("rand[%0d] nf=%0d", i, rnf), rbits, rnf, 1, 0, model_dout);
            end else begin
                run_frame($sformatf("rand[%0d] nf=%0d", i, rnf), rbits, rnf, 0, 1, model_dout);
            end
        end

        check("valid and error together", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side stage directly downstream of the team's SPI master; consumes its sclk/cs/mosi pins.
- Oversamples the three pins in the system clock domain and reassembles each LSB-first 12-bit frame.
- Presents each good word with a one-cycle valid pulse; flags malformed frames.
- Used as the loopback/DUT-side receiver in the SPI verification environment.

Parameters:
- DATA_W, 12, frame payload width in bits.
- LEAD, 1, leading sclk falling edges after cs falls that are discarded (master drives bit 0 one sclk period after asserting cs).
- SYNC_STAGES, 2, synchronizer depth for sclk/cs/mosi (minimum 2).

Ports:
- clk  input  1  system clock; sclk period must be >= 8 clk cycles (master gives 22).
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- sclk  input  1  serial clock from master, asynchronous to clk.
- cs  input  1  chip select from master, active-low.
- mosi  input  1  serial data from master, changes on sclk rising edge.
- dout  output  DATA_W  last correctly received word.
- dout_valid  output  1  one-clk pulse when dout updates.
- frame_err  output  1  one-clk pulse on a malformed frame.
- busy  output  1  high while a frame is in progress (state RECV).

Behaviour:
- Reset (rst=0, async): sync flops to sclk=0, cs=1, mosi=0; dout=0, dout_valid=0, frame_err=0, busy=0; state IDLE; edge counter and shift register 0.
- Synchronization: sclk, cs and mosi pass through identical SYNC_STAGES flop chains, so mosi stays aligned with the sclk edge detect. One further flop per signal provides the previous value for edge detection.
- sclk_fall = prev 1, synced 0. cs_fall and cs_rise are defined the same way.
- FSM states: IDLE, RECV.
  - IDLE + cs_fall: go to RECV; clear edge count and shift register; busy=1 from the next cycle.
  - IDLE ignores sclk entirely (cs high means sclk toggling is don't-care).
  - RECV + sclk_fall: edge count increments, saturating at LEAD+DATA_W+1.
    - If the pre-increment count is in [LEAD, LEAD+DATA_W-1], the shift register shifts right with mosi entering at the MSB. After DATA_W shifts, bit 0 holds the first payload bit (LSB-first).
    - Edges outside that window are not shifted.
  - RECV + cs_rise: go to IDLE.
    - If count == LEAD+DATA_W: dout <= shift register and dout_valid=1 for exactly one cycle.
    - Otherwise: frame_err=1 for one cycle and dout is unchanged.
- Simultaneous cs_rise and sclk_fall in RECV: cs_rise wins; the edge is not counted.
- Latency: dout_valid/frame_err are asserted SYNC_STAGES+1 clk cycles after the first clk edge that samples cs=1 on the pin (3 cycles at default).
- Back-to-back frames: a cs_fall in the cycle after returning to IDLE is accepted; no dead cycles beyond the synchronizer.
- Reset mid-frame: frame abandoned, no valid or error pulse, dout returns to 0.
- dout_valid and frame_err are never high in the same cycle.

Decomposition:
- Package spi_pkg:
  - typedef enum spi_rx_state_t {IDLE, RECV}
  - localparams SPI_DATA_W=12, SPI_LEAD=1
  - helper function for the edge-count width, $clog2(LEAD+DATA_W+2)
- Sub-module spi_sync: parameterized-width, SYNC_STAGES-deep, async-active-low-reset synchronizer with per-bit reset value. Instantiated once with width 3 for {cs, sclk, mosi}.

Test Plan:
- Master sends din=12'hA5C, newd pulse → exactly one dout_valid pulse with dout=12'hA5C; busy high only while cs low; frame_err never asserted.
- Back-to-back master frames 12'hFFF then 12'h001 → two valid pulses, dout=12'hFFF then 12'h001, no error.
- Bench-driven truncated frame: cs low, 7 sclk falling edges, cs high → frame_err pulse once; dout keeps previous 12'h001; no dout_valid.
- Overlong frame: 15 sclk falling edges inside cs low → frame_err once; dout unchanged.
- sclk toggling 40 periods with cs held high → busy, dout_valid and frame_err stay 0.
- rst driven 0 after 6 bits of a 12'h3C3 frame, released, then a clean 12'h3C3 frame → no pulse for the aborted frame; dout=0 after reset; one valid pulse with dout=12'h3C3 afterwards.
